// File: rtl/axi_master_arbiter_pkg.sv
// axi_master_arbiter_pkg: arbiter state encoding and width helper
package axi_master_arbiter_pkg;
  typedef enum logic [1:0] {ST_STARTUP, ST_IDLE, ST_WAIT, ST_RESP} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/axi_master_arbiter_rr.sv
// rr_priority_select: rotate by pointer, pick lowest requester, rotate back
module rr_priority_select
  import axi_master_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [N-1:0] rot;
  logic [IW-1:0] off;
  logic [IW:0] sum;
  assign rot = N'({req, req} >> ptr);
  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? IW'(k) : off;
  end
  assign valid  = |req;
  assign sum    = {1'b0, ptr} + {1'b0, off};
  assign idx    = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];
  assign winner = valid ? (N'(1) << idx) : '0;
endmodule

// File: rtl/axi_master_arbiter.sv
// axi_master_arbiter: round-robin sharing of one single-request AXI bridge among NUM_PORTS requesters
module axi_master_arbiter
  import axi_master_arbiter_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 128,
  parameter int STARTUP_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                             ACLK,
  input  logic                             ARESETN,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_addr,
  input  logic [NUM_PORTS-1:0]             s_read_enable,
  input  logic [NUM_PORTS-1:0]             s_write_enable,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_write_data,
  output logic [DATA_WIDTH-1:0]            s_read_data,
  output logic [NUM_PORTS-1:0]             s_ready,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic                             m_read_enable,
  output logic                             m_write_enable,
  output logic [DATA_WIDTH-1:0]            m_write_data,
  input  logic [DATA_WIDTH-1:0]            m_read_data,
  input  logic                             m_ready,
  output logic [NUM_PORTS-1:0]             grant,
  output logic                             timeout_error
);
  localparam int PW = clog2(NUM_PORTS);
  localparam int SW = clog2(STARTUP_CYCLES + 1);
  localparam int TW = clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_n;
  logic [PW-1:0] ptr, win_idx, own_idx;
  logic [SW-1:0] st_cnt;
  logic [TW-1:0] wd_cnt;
  logic [NUM_PORTS-1:0] req, win_oh;
  logic win_valid, st_done, wants_read;
  assign req        = s_read_enable | s_write_enable;
  assign st_done    = (STARTUP_CYCLES == 0) || (st_cnt == SW'(STARTUP_CYCLES - 1));
  assign wants_read = |(s_read_enable & win_oh);
  rr_priority_select #(.N(NUM_PORTS)) u_sel (
    .req    (req),
    .ptr    (ptr),
    .winner (win_oh),
    .idx    (win_idx),
    .valid  (win_valid)
  );
  always_comb begin
    state_n = state == ST_STARTUP ? (st_done ? ST_IDLE : ST_STARTUP) :
              state == ST_IDLE    ? (win_valid ? ST_WAIT : ST_IDLE) :
              state == ST_WAIT    ? (m_ready ? ST_RESP : ST_WAIT) : ST_IDLE;
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state          <= ST_STARTUP;
      st_cnt         <= '0;
      wd_cnt         <= '0;
      ptr            <= '0;
      own_idx        <= '0;
      grant          <= '0;
      s_ready        <= '0;
      s_read_data    <= '0;
      m_addr         <= '0;
      m_write_data   <= '0;
      m_read_enable  <= 1'b0;
      m_write_enable <= 1'b0;
      timeout_error  <= 1'b0;
    end else begin
      state          <= state_n;
      m_read_enable  <= 1'b0;
      m_write_enable <= 1'b0;
      s_ready        <= '0;
      case (state)
        ST_STARTUP: st_cnt <= st_cnt + 1'b1;
        ST_IDLE: if (win_valid) begin
          grant          <= win_oh;
          own_idx        <= win_idx;
          m_addr         <= s_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          m_write_data   <= s_write_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
          m_read_enable  <= wants_read;
          m_write_enable <= ~wants_read;
          wd_cnt         <= '0;
        end
        ST_WAIT: begin
          // the bridge cannot abort a burst, so the watchdog only flags
          if (wd_cnt != TW'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + 1'b1;
          if (TIMEOUT_CYCLES != 0 && wd_cnt == TW'(TIMEOUT_CYCLES - 1)) timeout_error <= 1'b1;
          if (m_ready) begin
            s_read_data <= m_read_data;
            s_ready     <= grant;
            ptr         <= (own_idx == PW'(NUM_PORTS - 1)) ? '0 : own_idx + 1'b1;
          end
        end
        default: grant <= '0;
      endcase
    end
  end
endmodule
